// File: rtl/dm_access_pkg.sv
// Shared definitions for the data-memory access controller.
//   OP_*     : request operation codes carried on req_op
//   ST_*     : controller FSM state encodings
//   op_size / is_store / is_rmw / is_signed / misaligned : request decode helpers
package dm_access_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Access size in bytes: 4, 2 or 1.
  function automatic logic [2:0] op_size(input logic [2:0] op);
    case (op)
      OP_LW, OP_SW:         return 3'd4;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd1;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Sub-word stores need a read of the surrounding word before writing.
  function automatic logic is_rmw(input logic [2:0] op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LB);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op_size(op))
      3'd4:    return lo != 2'b00;
      3'd2:    return lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_ctrl_byte_lane_unit.sv
// Combinational byte-lane steering between the word-wide DM and sub-word ops.
//   op       in  3   operation code
//   lane     in  2   byte address bits [1:0]
//   word     in  32  word read from DM
//   wdata    in  32  right-aligned store data
//   merged   out 32  word to write back (store lanes replaced in word)
//   load_val out 32  extracted and sign/zero-extended load value
module byte_lane_unit
  import dm_access_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = word;
    case (op)
      OP_LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: load_val = {24'h000000, byte_sel};
      OP_LH:  load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_val = {16'h0000, half_sel};
      OP_SW:  merged   = wdata;
      OP_SH:  merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      OP_SB:  merged[{lane, 3'b000} +: 8]      = wdata[7:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Initiator for the word-wide data memory: accepts one load/store at a time from
// the MEM stage, performs sub-word read-modify-write and load extension, and
// reports misaligned / out-of-range requests as exceptions without touching DM.
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_op/addr/wdata/pc       request fields
//   rsp_valid/rsp_rdata/rsp_exc  one-cycle completion pulse with result
//   WE/MemAddrRead/MemAddrWrite/WD/RD/PC  DM interface
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int unsigned DM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic        WE,
  output logic [31:0] MemAddrRead,
  output logic [31:0] MemAddrWrite,
  output logic [31:0] WD,
  input  logic [31:0] RD,
  output logic [31:0] PC
);

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] wbuf;
  logic [31:0] word_addr;
  logic        exc_q;

  logic [31:0] merged;
  logic [31:0] load_val;
  logic [32:0] req_end;
  logic        req_exc;
  logic        accept;

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign req_end   = {1'b0, req_addr} + {30'd0, op_size(req_op)};
  assign req_exc   = misaligned(req_op, req_addr[1:0]) || (req_end > 33'(DM_BYTES));
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  assign rsp_valid    = (state == ST_RESP);
  assign rsp_exc      = rsp_valid && exc_q;
  assign MemAddrRead  = word_addr;
  assign MemAddrWrite = word_addr;

  byte_lane_unit u_lane (
    .op       (op_q),
    .lane     (lane_q),
    .word     (RD),
    .wdata    (wdata_q),
    .merged   (merged),
    .load_val (load_val)
  );

  always_comb begin
    WE = 1'b0;
    WD = '0;
    if (!reset) begin
      if (state == ST_ACCESS && op_q == OP_SW) begin
        WE = 1'b1;
        WD = wdata_q;
      end else if (state == ST_WRITE) begin
        WE = 1'b1;
        WD = wbuf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      wbuf      <= '0;
      word_addr <= '0;
      exc_q     <= 1'b0;
      rsp_rdata <= '0;
      PC        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            PC        <= req_pc;
            exc_q     <= req_exc;
            rsp_rdata <= '0;
            // Faulting addresses are never presented to DM.
            word_addr <= req_exc ? '0 : {req_addr[31:2], 2'b00};
            state     <= req_exc ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (is_rmw(op_q)) begin
            wbuf  <= merged;
            state <= ST_WRITE;
          end else begin
            if (!is_store(op_q)) rsp_rdata <= load_val;
            state <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;
  import dm_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
  logic        rsp_valid, rsp_exc;
  logic [31:0] rsp_rdata;
  logic        WE;
  logic [31:0] MemAddrRead, MemAddrWrite, WD, RD, PC;

  always #5 clk = ~clk;

  dm_access_ctrl #(.DM_BYTES(4096)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc),
    .WE(WE), .MemAddrRead(MemAddrRead), .MemAddrWrite(MemAddrWrite),
    .WD(WD), .RD(RD), .PC(PC)
  );

  // Word-only DM environment model.
  logic [31:0] dm [0:1023];
  assign RD = dm[MemAddrRead[11:2]];
  always @(posedge clk) if (WE) dm[MemAddrWrite[11:2]] <= WD;

  // Reference: byte-addressed memory, updated when a request is issued.
  logic [7:0] refm [0:4095];

  typedef struct { logic [31:0] rdata; logic exc; int lat; int acc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t e;
  wr_t  w;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input int acc);
    int size;
    longint unsigned endb;
    int unsigned v;
    rsp_t r;
    wr_t  x;
    size = (op == OP_LW || op == OP_SW) ? 4 :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
    endb = {32'd0, addr} + longint'(size);
    r.acc = acc;
    if ((addr % size) != 0 || endb > 4096) begin
      r.rdata = 0; r.exc = 1'b1; r.lat = 1;
    end else if (op == OP_SW || op == OP_SH || op == OP_SB) begin
      for (int i = 0; i < size; i++) refm[addr + i] = 8'((wd >> (8 * i)) & 32'hFF);
      x.addr = addr & ~32'd3;
      x.data = {refm[x.addr + 3], refm[x.addr + 2], refm[x.addr + 1], refm[x.addr]};
      x.cyc  = acc + ((op == OP_SW) ? 1 : 2);
      wr_q.push_back(x);
      r.rdata = 0; r.exc = 1'b0; r.lat = (op == OP_SW) ? 2 : 3;
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (int'(refm[addr + i]) << (8 * i));
      if ((op == OP_LB || op == OP_LH) && v[8 * size - 1]) v = v | (32'hFFFFFFFF << (8 * size));
      r.rdata = v; r.exc = 1'b0; r.lat = 2;
    end
    rsp_q.push_back(r);
  endfunction

  // Monitor: responses and DM writes popped against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_exc", 32'(rsp_exc), 32'(e.exc));
          chk("rsp_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
        end
      end
      if (WE) begin
        if (wr_q.size() == 0) chk("unexpected_write", MemAddrWrite, 32'hFFFFFFFF);
        else begin
          w = wr_q.pop_front();
          chk("dm_write_addr", MemAddrWrite, w.addr);
          chk("dm_write_data", WD, w.data);
          chk("dm_write_cycle", 32'(cyc + 1), 32'(w.cyc));
        end
      end
    end
  end

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input bit track, input bit keep, output int acc);
    logic [31:0] pcv;
    pcv = $urandom;
    req_op = op; req_addr = addr; req_wdata = wd; req_pc = pcv; req_valid = 1'b1;
    acc = -1;
    for (int b = 0; b < 50; b++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (track) model(op, addr, wd, acc);
    @(posedge clk);
    #1;
    chk("pc_latched", PC, pcv);
    if (!keep) req_valid = 1'b0;
  endtask

  int a1, a2;
  logic [2:0] rop;
  logic [31:0] raddr;
  int sel;

  initial begin
    for (int i = 0; i < 1024; i++) dm[i] = '0;
    for (int i = 0; i < 4096; i++) refm[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_exc", 32'(rsp_exc), 32'd0);
    chk("reset_we", 32'(WE), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_pc", PC, 32'd0);
    chk("reset_raddr", MemAddrRead, 32'd0);
    chk("reset_waddr", MemAddrWrite, 32'd0);
    @(posedge clk); #1;

    // Word store then load.
    do_req(OP_SW, 32'h10, 32'h12345678, 1, 0, a1);
    do_req(OP_LW, 32'h10, 32'h0, 1, 0, a1);
    // Byte RMW and zero-extended byte load.
    do_req(OP_SW, 32'h20, 32'h11223344, 1, 0, a1);
    do_req(OP_SB, 32'h21, 32'hFFFFFFAB, 1, 0, a1);
    do_req(OP_LBU, 32'h21, 32'h0, 1, 0, a1);
    // Sign / zero extension.
    do_req(OP_SW, 32'h30, 32'h8000FF80, 1, 0, a1);
    do_req(OP_LB, 32'h30, 32'h0, 1, 0, a1);
    do_req(OP_LH, 32'h32, 32'h0, 1, 0, a1);
    do_req(OP_LHU, 32'h30, 32'h0, 1, 0, a1);
    do_req(OP_SH, 32'h32, 32'h1234BEEF, 1, 0, a1);
    do_req(OP_LW, 32'h30, 32'h0, 1, 0, a1);
    // Faults and range boundary.
    do_req(OP_LW, 32'h13, 32'h0, 1, 0, a1);
    do_req(OP_SH, 32'h31, 32'hFFFF, 1, 0, a1);
    do_req(OP_SB, 32'h1000, 32'hAA, 1, 0, a1);
    do_req(OP_SW, 32'hFFC, 32'hCAFEF00D, 1, 0, a1);
    do_req(OP_LW, 32'hFFC, 32'h0, 1, 0, a1);
    do_req(OP_LH, 32'hFFE, 32'h0, 1, 0, a1);
    do_req(OP_LW, 32'hFFFFFFFC, 32'h0, 1, 0, a1);

    // Reset during the WRITE cycle of an sb abandons it.
    do_req(OP_SW, 32'h40, 32'h5555AAAA, 1, 0, a1);
    repeat (4) @(posedge clk); #1;
    do_req(OP_SB, 32'h40, 32'h000000CD, 0, 0, a1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("we_during_reset", 32'(WE), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    do_req(OP_LW, 32'h40, 32'h0, 1, 0, a1);

    // Back-to-back with req_valid held high.
    do_req(OP_SW, 32'h50, 32'hDEADBEEF, 1, 1, a1);
    do_req(OP_LW, 32'h50, 32'h0, 1, 0, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      rop = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 7)      raddr = 32'($urandom_range(0, 127));
      else if (sel < 9) raddr = 32'(4088 + $urandom_range(0, 15));
      else              raddr = $urandom;
      do_req(rop, raddr, $urandom, 1, ($urandom_range(0, 3) == 0), a1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;

    for (int b = 0; b < 40; b++) begin
      if (rsp_q.size() == 0 && wr_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
